// File: rtl/reg_write_arbiter_if.sv
// Writeback bundle between execute/memory, issue logic and the register-file write port.
// master = producers/issue side, slave = reg_write_arbiter.
interface reg_write_arbiter_if #(
  parameter int NREGS = 8,
  parameter int AW    = 3,
  parameter int DW    = 8
);
  logic             aluValid;
  logic             aluReady;
  logic [AW-1:0]    aluDest;
  logic [DW-1:0]    aluData;
  logic             ldValid;
  logic             ldReady;
  logic [AW-1:0]    ldDest;
  logic [DW-1:0]    ldData;
  logic             pendSet;
  logic [AW-1:0]    pendDest;
  logic [AW-1:0]    chkA;
  logic [AW-1:0]    chkB;
  logic             stall;
  logic             rfWrite;
  logic [AW-1:0]    rfAddr;
  logic [DW-1:0]    rfData;
  logic [NREGS-1:0] pending;
  logic             idle;

  modport master (
    output aluValid, aluDest, aluData, ldValid, ldDest, ldData,
           pendSet, pendDest, chkA, chkB,
    input  aluReady, ldReady, stall, rfWrite, rfAddr, rfData, pending, idle
  );

  modport slave (
    input  aluValid, aluDest, aluData, ldValid, ldDest, ldData,
           pendSet, pendDest, chkA, chkB,
    output aluReady, ldReady, stall, rfWrite, rfAddr, rfData, pending, idle
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin merge of ALU and load writebacks onto one register-file write port; push at edge k writes at k+1.
// Each source has a DEPTH-entry FIFO; ready drops when its FIFO is full (no bypass), plus a load-pending scoreboard.
module reg_write_arbiter #(
  parameter int NREGS = 8,
  parameter int AW    = 3,
  parameter int DW    = 8,
  parameter int DEPTH = 2
) (
  input logic                clock,
  input logic                resetN,
  reg_write_arbiter_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LASTPTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULLCNT = CW'(DEPTH);

  localparam logic [0:0] GRANT_ALU = 1'b0;
  localparam logic [0:0] GRANT_LD  = 1'b1;

  logic [AW-1:0]    aluDestMem [DEPTH];
  logic [DW-1:0]    aluDataMem [DEPTH];
  logic [AW-1:0]    ldDestMem  [DEPTH];
  logic [DW-1:0]    ldDataMem  [DEPTH];
  logic [PW-1:0]    aluWrPtr, aluRdPtr, ldWrPtr, ldRdPtr;
  logic [CW-1:0]    aluCount, ldCount;
  logic             aluReadyInt, ldReadyInt;
  logic             aluPush, ldPush;
  logic             aluHas, ldHas;
  logic             grantAlu, grantLd;
  logic [0:0]       lastGrant;
  logic [AW-1:0]    aluHeadDest, ldHeadDest;
  logic [DW-1:0]    aluHeadData, ldHeadData;
  logic [NREGS-1:0] pendingQ, pendingNext;
  logic             rfWriteQ;
  logic [AW-1:0]    rfAddrQ;
  logic [DW-1:0]    rfDataQ;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == LASTPTR) ? '0 : p + 1'b1;
  endfunction

  assign aluReadyInt = (aluCount != FULLCNT);
  assign ldReadyInt  = (ldCount != FULLCNT);
  assign aluPush     = bus.aluValid && aluReadyInt;
  assign ldPush      = bus.ldValid && ldReadyInt;
  assign aluHas      = (aluCount != '0);
  assign ldHas       = (ldCount != '0);

  assign aluHeadDest = aluDestMem[aluRdPtr];
  assign aluHeadData = aluDataMem[aluRdPtr];
  assign ldHeadDest  = ldDestMem[ldRdPtr];
  assign ldHeadData  = ldDataMem[ldRdPtr];

  // Under contention the source that did not win last time gets the port.
  assign grantAlu = aluHas && (!ldHas || (lastGrant == GRANT_LD));
  assign grantLd  = ldHas && !grantAlu;

  always_comb begin
    pendingNext = pendingQ;
    if (grantLd) begin
      pendingNext[ldHeadDest] = 1'b0;
    end
    // A newly issued load to the same register outranks the retiring one.
    if (bus.pendSet) begin
      pendingNext[bus.pendDest] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (aluPush) begin
      aluDestMem[aluWrPtr] <= bus.aluDest;
      aluDataMem[aluWrPtr] <= bus.aluData;
    end
    if (ldPush) begin
      ldDestMem[ldWrPtr] <= bus.ldDest;
      ldDataMem[ldWrPtr] <= bus.ldData;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      aluWrPtr  <= '0;
      aluRdPtr  <= '0;
      aluCount  <= '0;
      ldWrPtr   <= '0;
      ldRdPtr   <= '0;
      ldCount   <= '0;
      lastGrant <= GRANT_LD;
      pendingQ  <= '0;
      rfWriteQ  <= 1'b0;
      rfAddrQ   <= '0;
      rfDataQ   <= '0;
    end else begin
      if (aluPush) begin
        aluWrPtr <= nextPtr(aluWrPtr);
      end
      if (grantAlu) begin
        aluRdPtr <= nextPtr(aluRdPtr);
      end
      aluCount <= aluCount + CW'(aluPush) - CW'(grantAlu);

      if (ldPush) begin
        ldWrPtr <= nextPtr(ldWrPtr);
      end
      if (grantLd) begin
        ldRdPtr <= nextPtr(ldRdPtr);
      end
      ldCount <= ldCount + CW'(ldPush) - CW'(grantLd);

      // Only a contended grant moves the round-robin pointer.
      if (aluHas && ldHas) begin
        lastGrant <= grantAlu ? GRANT_ALU : GRANT_LD;
      end

      pendingQ <= pendingNext;
      rfWriteQ <= grantAlu || grantLd;
      if (grantAlu) begin
        rfAddrQ <= aluHeadDest;
        rfDataQ <= aluHeadData;
      end else if (grantLd) begin
        rfAddrQ <= ldHeadDest;
        rfDataQ <= ldHeadData;
      end
    end
  end

  assign bus.aluReady = aluReadyInt;
  assign bus.ldReady  = ldReadyInt;
  assign bus.stall    = pendingQ[bus.chkA] | pendingQ[bus.chkB];
  assign bus.rfWrite  = rfWriteQ;
  assign bus.rfAddr   = rfAddrQ;
  assign bus.rfData   = rfDataQ;
  assign bus.pending  = pendingQ;
  assign bus.idle     = !aluHas && !ldHas && !rfWriteQ;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: per-cycle vector table plus hand sequences
// for backpressure and mid-operation reset.
module tb_reg_write_arbiter;
  logic clock = 1'b0;
  logic resetN = 1'b0;
  int   passCount = 0;
  int   totalCount = 0;

  always #5 clock = ~clock;

  reg_write_arbiter_if #(.NREGS(8), .AW(3), .DW(8)) bus ();

  reg_write_arbiter #(.NREGS(8), .AW(3), .DW(8), .DEPTH(2)) dut (
    .clock (clock),
    .resetN(resetN),
    .bus   (bus.slave)
  );

  typedef struct {
    logic       rstN;
    logic       aV;
    logic [2:0] aD;
    logic [7:0] aX;
    logic       lV;
    logic [2:0] lD;
    logic [7:0] lX;
    logic       pS;
    logic [2:0] pD;
    logic [2:0] cA;
    logic [2:0] cB;
    logic       eW;
    logic [2:0] eA;
    logic [7:0] eX;
    logic [7:0] eP;
    logic       eAR;
    logic       eLR;
    logic       eIdle;
    logic       eStall;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic rstN, input logic aV, input logic [2:0] aD, input logic [7:0] aX,
    input logic lV, input logic [2:0] lD, input logic [7:0] lX,
    input logic pS, input logic [2:0] pD, input logic [2:0] cA, input logic [2:0] cB,
    input logic eW, input logic [2:0] eA, input logic [7:0] eX, input logic [7:0] eP,
    input logic eAR, input logic eLR, input logic eIdle, input logic eStall);
    vec_t v;
    v.rstN = rstN; v.aV = aV; v.aD = aD; v.aX = aX;
    v.lV = lV; v.lD = lD; v.lX = lX;
    v.pS = pS; v.pD = pD; v.cA = cA; v.cB = cB;
    v.eW = eW; v.eA = eA; v.eX = eX; v.eP = eP;
    v.eAR = eAR; v.eLR = eLR; v.eIdle = eIdle; v.eStall = eStall;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idleIn();
    bus.aluValid = 1'b0; bus.aluDest = '0; bus.aluData = '0;
    bus.ldValid  = 1'b0; bus.ldDest  = '0; bus.ldData  = '0;
    bus.pendSet  = 1'b0; bus.pendDest = '0;
    bus.chkA     = '0;   bus.chkB    = '0;
  endtask

  task automatic chkW(input string name, input logic w, input logic [2:0] a, input logic [7:0] d);
    check({name, " rfWrite"}, 32'(bus.rfWrite), 32'(w));
    check({name, " rfAddr"}, 32'(bus.rfAddr), 32'(a));
    check({name, " rfData"}, 32'(bus.rfData), 32'(d));
  endtask

  initial begin
    idleIn();
    //                rst aV aD aX     lV lD lX     pS pD cA cB | eW eA eX     eP     AR LR Id St
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0,   0, 0, 8'h00, 8'h00, 1, 1, 1, 0));
    vecs.push_back(mk(1, 1, 3, 8'h5A, 0, 0, 8'h00, 0, 0, 0, 0,   0, 0, 8'h00, 8'h00, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0,   1, 3, 8'h5A, 8'h00, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0,   0, 3, 8'h5A, 8'h00, 1, 1, 1, 0));
    vecs.push_back(mk(1, 1, 1, 8'h11, 1, 2, 8'h22, 0, 0, 0, 0,   0, 3, 8'h5A, 8'h00, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0,   1, 1, 8'h11, 8'h00, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0,   1, 2, 8'h22, 8'h00, 1, 1, 0, 0));
    vecs.push_back(mk(1, 1, 3, 8'h33, 1, 4, 8'h44, 0, 0, 0, 0,   0, 2, 8'h22, 8'h00, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0,   1, 4, 8'h44, 8'h00, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0,   1, 3, 8'h33, 8'h00, 1, 1, 0, 0));
    vecs.push_back(mk(1, 1, 5, 8'h55, 1, 6, 8'h66, 0, 0, 0, 0,   0, 3, 8'h33, 8'h00, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0,   1, 5, 8'h55, 8'h00, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0,   1, 6, 8'h66, 8'h00, 1, 1, 0, 0));
    vecs.push_back(mk(1, 1, 7, 8'h77, 1, 0, 8'h88, 0, 0, 0, 0,   0, 6, 8'h66, 8'h00, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0,   1, 0, 8'h88, 8'h00, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0,   1, 7, 8'h77, 8'h00, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0,   0, 7, 8'h77, 8'h00, 1, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 1, 5, 5, 0,   0, 7, 8'h77, 8'h20, 1, 1, 1, 1));
    vecs.push_back(mk(1, 0, 0, 8'h00, 1, 5, 8'hA5, 0, 0, 5, 0,   0, 7, 8'h77, 8'h20, 1, 1, 0, 1));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 5, 0,   1, 5, 8'hA5, 8'h00, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 1, 5, 8'hB6, 1, 5, 5, 0,   0, 5, 8'hA5, 8'h20, 1, 1, 0, 1));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 1, 5, 5, 0,   1, 5, 8'hB6, 8'h20, 1, 1, 0, 1));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 5,   0, 5, 8'hB6, 8'h20, 1, 1, 1, 1));
    vecs.push_back(mk(1, 0, 0, 8'h00, 1, 5, 8'hC7, 0, 0, 0, 0,   0, 5, 8'hB6, 8'h20, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 2, 0,   1, 5, 8'hC7, 8'h00, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0,   0, 5, 8'hC7, 8'h00, 1, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 1, 1, 1, 0,   0, 5, 8'hC7, 8'h02, 1, 1, 1, 1));
    vecs.push_back(mk(1, 1, 1, 8'hD8, 0, 0, 8'h00, 0, 0, 1, 0,   0, 5, 8'hC7, 8'h02, 1, 1, 0, 1));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0,   1, 1, 8'hD8, 8'h02, 1, 1, 0, 1));
    vecs.push_back(mk(1, 0, 0, 8'h00, 1, 1, 8'hE9, 0, 0, 1, 0,   0, 1, 8'hD8, 8'h02, 1, 1, 0, 1));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0,   1, 1, 8'hE9, 8'h00, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0,   0, 1, 8'hE9, 8'h00, 1, 1, 1, 0));

    foreach (vecs[i]) begin
      resetN = vecs[i].rstN;
      bus.aluValid = vecs[i].aV; bus.aluDest = vecs[i].aD; bus.aluData = vecs[i].aX;
      bus.ldValid = vecs[i].lV;  bus.ldDest = vecs[i].lD;  bus.ldData = vecs[i].lX;
      bus.pendSet = vecs[i].pS;  bus.pendDest = vecs[i].pD;
      bus.chkA = vecs[i].cA;     bus.chkB = vecs[i].cB;
      tick();
      chkW($sformatf("v%0d", i), vecs[i].eW, vecs[i].eA, vecs[i].eX);
      check($sformatf("v%0d pending", i), 32'(bus.pending), 32'(vecs[i].eP));
      check($sformatf("v%0d aluReady", i), 32'(bus.aluReady), 32'(vecs[i].eAR));
      check($sformatf("v%0d ldReady", i), 32'(bus.ldReady), 32'(vecs[i].eLR));
      check($sformatf("v%0d idle", i), 32'(bus.idle), 32'(vecs[i].eIdle));
      check($sformatf("v%0d stall", i), 32'(bus.stall), 32'(vecs[i].eStall));
    end

    // Backpressure: fill the ALU FIFO while the load side wins, then hold a valid.
    idleIn();
    bus.aluValid = 1; bus.aluDest = 1; bus.aluData = 8'hA0;
    bus.ldValid = 1;  bus.ldDest = 2;  bus.ldData = 8'hB0;
    tick();
    idleIn();
    bus.ldValid = 1; bus.ldDest = 3; bus.ldData = 8'hB1;
    tick();
    chkW("bp e2", 1, 1, 8'hA0);
    check("bp e2 ldReady", 32'(bus.ldReady), 32'd0);
    idleIn();
    bus.aluValid = 1; bus.aluDest = 4; bus.aluData = 8'hA1;
    tick();
    chkW("bp e3", 1, 2, 8'hB0);
    idleIn();
    bus.aluValid = 1; bus.aluDest = 5; bus.aluData = 8'hA2;
    bus.ldValid = 1;  bus.ldDest = 6;  bus.ldData = 8'hB2;
    tick();
    chkW("bp e4", 1, 3, 8'hB1);
    check("bp e4 aluReady", 32'(bus.aluReady), 32'd0);
    idleIn();
    bus.aluValid = 1; bus.aluDest = 7; bus.aluData = 8'hA3;
    tick();
    chkW("bp e5", 1, 4, 8'hA1);
    check("bp e5 aluReady", 32'(bus.aluReady), 32'd1);
    tick();
    chkW("bp e6", 1, 6, 8'hB2);
    check("bp e6 aluReady", 32'(bus.aluReady), 32'd0);
    tick();
    chkW("bp e7", 1, 5, 8'hA2);
    idleIn();
    tick();
    chkW("bp e8", 1, 7, 8'hA3);
    tick();
    chkW("bp e9", 0, 7, 8'hA3);
    check("bp e9 idle", 32'(bus.idle), 32'd1);

    // Reset with writes queued and loads pending.
    idleIn();
    bus.aluValid = 1; bus.aluDest = 1; bus.aluData = 8'hC1;
    bus.ldValid = 1;  bus.ldDest = 2;  bus.ldData = 8'hC2;
    bus.pendSet = 1;  bus.pendDest = 6; bus.chkA = 6;
    #1;
    check("rs same-cycle stall", 32'(bus.stall), 32'd0);
    tick();
    check("rs f1 stall", 32'(bus.stall), 32'd1);
    idleIn();
    bus.aluValid = 1; bus.aluDest = 3; bus.aluData = 8'hC3;
    bus.ldValid = 1;  bus.ldDest = 4;  bus.ldData = 8'hC4;
    bus.pendSet = 1;  bus.pendDest = 7;
    tick();
    chkW("rs f2", 1, 1, 8'hC1);
    check("rs f2 pending", 32'(bus.pending), 32'hC0);
    idleIn();
    resetN = 1'b0;
    tick();
    chkW("rs f3", 0, 0, 8'h00);
    check("rs f3 pending", 32'(bus.pending), 32'd0);
    check("rs f3 aluReady", 32'(bus.aluReady), 32'd1);
    check("rs f3 ldReady", 32'(bus.ldReady), 32'd1);
    check("rs f3 idle", 32'(bus.idle), 32'd1);
    resetN = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("rs drain%0d rfWrite", k), 32'(bus.rfWrite), 32'd0);
      check($sformatf("rs drain%0d idle", k), 32'(bus.idle), 32'd1);
    end
    bus.aluValid = 1; bus.aluDest = 2; bus.aluData = 8'h12;
    bus.ldValid = 1;  bus.ldDest = 3;  bus.ldData = 8'h13;
    tick();
    idleIn();
    tick();
    chkW("rs post alu", 1, 2, 8'h12);
    tick();
    chkW("rs post ld", 1, 3, 8'h13);
    tick();
    chkW("rs post end", 0, 3, 8'h13);
    check("rs post idle", 32'(bus.idle), 32'd1);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end
endmodule
